// File: rtl/ula_pkg.sv
// Shared types and the saturation helper for the sequential ULA.
package ula_pkg;

  localparam int unsigned SAT_W = 64;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_XOR = 3'b100,
    OP_SLT = 3'b101,
    OP_MUL = 3'b110,
    OP_RSV = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  // Clamps to the most negative (sign=1) or most positive value of a
  // width-bit signed number; callers truncate the result to their width.
  function automatic logic [SAT_W-1:0] sat(input logic [SAT_W-1:0] value,
                                           input logic overflow,
                                           input logic sign,
                                           input int unsigned width);
    logic [SAT_W-1:0] minVal;
    minVal = SAT_W'(1) << (width - 1);
    if (!overflow) return value;
    return sign ? minVal : (minVal - SAT_W'(1));
  endfunction

endpackage

// File: rtl/ula_seq_if.sv
// Operand/result handshake bundle between a sequencer (master) and ula_seq (slave).
interface ula_seq_if #(
  parameter int Bits = 8
);
  import ula_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [Bits-1:0] A;
  logic [Bits-1:0] B;
  logic [2:0]      F;
  logic            out_valid;
  logic            out_ready;
  logic [Bits-1:0] Saida;
  logic            FLAG_O;
  logic            FLAG_Z;
  logic            FLAG_N;

  modport master (
    output in_valid, A, B, F, out_ready,
    input  in_ready, out_valid, Saida, FLAG_O, FLAG_Z, FLAG_N
  );

  modport slave (
    input  in_valid, A, B, F, out_ready,
    output in_ready, out_valid, Saida, FLAG_O, FLAG_Z, FLAG_N
  );

endinterface

// File: rtl/ula_mul_seq.sv
// Iterative signed multiplier: magnitude shift-add over Bits cycles, sign fixed at the output.
module ula_mul_seq
  import ula_pkg::*;
#(
  parameter int Bits = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [Bits-1:0]   a_i,
  input  logic [Bits-1:0]   b_i,
  output logic              done_o,
  output logic [2*Bits-1:0] product_o
);

  localparam int MSB = Bits - 1;
  localparam int CW  = $clog2(Bits + 1);

  logic              busy_q, busy_d;
  logic              neg_q, neg_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*Bits-1:0] acc_q, acc_d;
  logic [2*Bits-1:0] mcand_q, mcand_d;
  logic [Bits-1:0]   mplier_q, mplier_d;
  logic [Bits-1:0]   magA, magB;

  // Magnitude of -2^(Bits-1) is 2^(Bits-1), which still fits unsigned.
  assign magA = a_i[MSB] ? -a_i : a_i;
  assign magB = b_i[MSB] ? -b_i : b_i;

  // The first partial product is folded into the start cycle so the
  // product is complete Bits cycles after start.
  always_comb begin
    busy_d   = busy_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (start_i) begin
      busy_d   = 1'b1;
      neg_d    = a_i[MSB] ^ b_i[MSB];
      cnt_d    = CW'(1);
      acc_d    = magB[0] ? {{Bits{1'b0}}, magA} : '0;
      mcand_d  = {{(Bits-1){1'b0}}, magA, 1'b0};
      mplier_d = magB >> 1;
    end else if (busy_q) begin
      if (cnt_q == CW'(Bits)) begin
        busy_d = 1'b0;
      end else begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q   <= 1'b0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      busy_q   <= busy_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  assign done_o    = busy_q && (cnt_q == CW'(Bits));
  assign product_o = neg_q ? -acc_q : acc_q;

endmodule

// File: rtl/ula_seq.sv
// Sequential signed ULA with valid/ready handshake and registered flags.
// Define ULA_SAT_EN to clamp ADD/SUB/MUL on overflow instead of wrapping.
module ula_seq
  import ula_pkg::*;
#(
  parameter int Bits = 8
) (
  input logic        clk,
  input logic        reset,
  ula_seq_if.slave   bus
);

  localparam int MSB = Bits - 1;

  state_t            state_q, state_d;
  logic [Bits-1:0]   saida_q, saida_d;
  logic              flagO_q, flagO_d;
  logic              flagZ_q, flagZ_d;
  logic              flagN_q, flagN_d;

  op_t               op;
  logic              inReady;
  logic              accept;
  logic              isMul;
  logic              mulStart;
  logic              mulDone;
  logic              loadAlu;
  logic              loadMul;
  logic [2*Bits-1:0] mulProd;
  logic [Bits-1:0]   sum, diff;
  logic [Bits-1:0]   aluRes, mulRes;
  logic              aluOv, mulOv;

  assign op      = op_t'(bus.F);
  assign isMul   = (op == OP_MUL);
  assign inReady = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign accept  = bus.in_valid && inReady;

  ula_mul_seq #(.Bits(Bits)) u_mul (
    .clk       (clk),
    .reset     (reset),
    .start_i   (mulStart),
    .a_i       (bus.A),
    .b_i       (bus.B),
    .done_o    (mulDone),
    .product_o (mulProd)
  );

  // Single-cycle ops; the true sign of an ADD/SUB overflow is A's sign.
  always_comb begin
    sum    = bus.A + bus.B;
    diff   = bus.A - bus.B;
    aluRes = '0;
    aluOv  = 1'b0;
    case (op)
      OP_AND: aluRes = bus.A & bus.B;
      OP_OR:  aluRes = bus.A | bus.B;
      OP_XOR: aluRes = bus.A ^ bus.B;
      OP_SLT: aluRes = {{(Bits-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      OP_ADD: begin
        aluOv = (bus.A[MSB] == bus.B[MSB]) && (sum[MSB] != bus.A[MSB]);
`ifdef ULA_SAT_EN
        aluRes = Bits'(sat(SAT_W'(sum), aluOv, bus.A[MSB], Bits));
`else
        aluRes = sum;
`endif
      end
      OP_SUB: begin
        aluOv = (bus.A[MSB] != bus.B[MSB]) && (diff[MSB] != bus.A[MSB]);
`ifdef ULA_SAT_EN
        aluRes = Bits'(sat(SAT_W'(diff), aluOv, bus.A[MSB], Bits));
`else
        aluRes = diff;
`endif
      end
      OP_RSV: aluOv = 1'b1;
      default: aluRes = '0;
    endcase
  end

  // The product fits Bits signed only if its top Bits+1 bits are all equal.
  always_comb begin
    mulOv = !(&mulProd[2*Bits-1:MSB]) && (|mulProd[2*Bits-1:MSB]);
`ifdef ULA_SAT_EN
    mulRes = Bits'(sat(SAT_W'(mulProd[MSB:0]), mulOv, mulProd[2*Bits-1], Bits));
`else
    mulRes = mulProd[MSB:0];
`endif
  end

  always_comb begin
    state_d  = state_q;
    saida_d  = saida_q;
    flagO_d  = flagO_q;
    flagZ_d  = flagZ_q;
    flagN_d  = flagN_q;
    mulStart = 1'b0;
    loadAlu  = 1'b0;
    loadMul  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          if (isMul) begin
            state_d  = BUSY;
            mulStart = 1'b1;
          end else begin
            state_d = DONE;
            loadAlu = 1'b1;
          end
        end else if ((state_q == DONE) && bus.out_ready) begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (mulDone) begin
          state_d = DONE;
          loadMul = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (loadAlu) begin
      saida_d = aluRes;
      flagO_d = aluOv;
    end else if (loadMul) begin
      saida_d = mulRes;
      flagO_d = mulOv;
    end
    if (loadAlu || loadMul) begin
      flagZ_d = (saida_d == '0);
      flagN_d = saida_d[MSB];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      saida_q <= '0;
      flagO_q <= 1'b0;
      flagZ_q <= 1'b0;
      flagN_q <= 1'b0;
    end else begin
      state_q <= state_d;
      saida_q <= saida_d;
      flagO_q <= flagO_d;
      flagZ_q <= flagZ_d;
      flagN_q <= flagN_d;
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.out_valid = (state_q == DONE);
  assign bus.Saida     = saida_q;
  assign bus.FLAG_O    = flagO_q;
  assign bus.FLAG_Z    = flagZ_q;
  assign bus.FLAG_N    = flagN_q;

endmodule
